pipe_stage_reg: RTL and testbench

Parametrised, elastic inter-stage pipeline register for the ICARUS datapath, generalising the fixed MEM/WB latch to any stage boundary (IF/ID, ID/EX, EX/MEM, MEM/WB). Carries a control bundle and a data bundle of configurable width through a two-entry skid buffer with valid/ready handshaking, so back-pressure does not create a combinational ready path across stages. Supports synchronous flush for branch/exception squash and guarantees that invalid slots present all-zero control, so a bubble can never assert RegWrite or MemWrite downstream.

---
 rtl/pipe_stage_pkg.sv | 35 +++
 rtl/pipe_skid_slot.sv | 53 +++++
 rtl/pipe_stage_reg.sv | 157 +++++++++++++++
 tb/tb_pipe_stage_reg.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_stage_pkg.sv
// Shared definitions for the elastic inter-stage pipeline register:
// state encoding, per-boundary default widths and small decode helpers.
package pipe_stage_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_HALF  = 2'd1,
    ST_FULL  = 2'd2
  } pipe_state_e;

  // Default bundle widths for each ICARUS stage boundary
  localparam int IFID_CTRL_W  = 1;
  localparam int IFID_DATA_W  = 64;
  localparam int IDEX_CTRL_W  = 10;
  localparam int IDEX_DATA_W  = 128;
  localparam int EXMEM_CTRL_W = 4;
  localparam int EXMEM_DATA_W = 101;
  localparam int MEMWB_CTRL_W = 4;
  localparam int MEMWB_DATA_W = 128;

  function automatic pipe_state_e state_of(input logic m_valid, input logic s_valid);
    if (s_valid)      return ST_FULL;
    else if (m_valid) return ST_HALF;
    else              return ST_EMPTY;
  endfunction

  function automatic logic [1:0] occ_of(input pipe_state_e st);
    case (st)
      ST_HALF: return 2'd1;
      ST_FULL: return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/pipe_skid_slot.sv
// One {valid, ctrl, data} storage slot with load and clear enables.
// Clear drops only the valid bit so the data bundle keeps its last value.
module pipe_skid_slot
  import pipe_stage_pkg::*;
#(
  parameter int CTRL_W = 4,
  parameter int DATA_W = 128
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              load,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              valid,
  output logic [CTRL_W-1:0] ctrl,
  output logic [DATA_W-1:0] data
);

  logic              valid_d, valid_q;
  logic [CTRL_W-1:0] ctrl_d, ctrl_q;
  logic [DATA_W-1:0] data_d, data_q;

  always_comb begin
    valid_d = valid_q;
    ctrl_d  = ctrl_q;
    data_d  = data_q;
    if (clr) begin
      valid_d = 1'b0;
    end else if (load) begin
      valid_d = 1'b1;
      ctrl_d  = in_ctrl;
      data_d  = in_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      ctrl_q  <= ctrl_d;
      data_q  <= data_d;
    end
  end

  assign valid = valid_q;
  assign ctrl  = ctrl_q;
  assign data  = data_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Elastic two-entry skid-buffer pipeline register with flush and bubble-safe control.
// Define PIPE_STAGE_PERF_EN to add saturating StallCount/BubbleCount counters.
module pipe_stage_reg
  import pipe_stage_pkg::*;
#(
  parameter int CTRL_W = 4,
  parameter int DATA_W = 128,
  parameter int CNT_W  = 32
) (
  input  logic              Clock,
  input  logic              Reset_n,
  input  logic              Flush,
  input  logic              In_Valid,
  output logic              In_Ready,
  input  logic [CTRL_W-1:0] In_Ctrl,
  input  logic [DATA_W-1:0] In_Data,
  output logic              Out_Valid,
  input  logic              Out_Ready,
  output logic [CTRL_W-1:0] Out_Ctrl,
  output logic [DATA_W-1:0] Out_Data,
  output logic [1:0]        Occupancy
`ifdef PIPE_STAGE_PERF_EN
  ,
  output logic [CNT_W-1:0]  StallCount,
  output logic [CNT_W-1:0]  BubbleCount
`endif
);

  if (CTRL_W < 1 || DATA_W < 1 || CNT_W < 1) begin : g_bad_width
    $error("pipe_stage_reg: widths must be positive");
  end

  logic              m_valid, s_valid;
  logic [CTRL_W-1:0] m_ctrl, s_ctrl, m_ctrl_in;
  logic [DATA_W-1:0] m_data, s_data, m_data_in;
  logic              m_load, m_clr, m_from_s, s_load, s_clr;
  logic              push, pop;
  logic              in_ready_d, in_ready_q;
  pipe_state_e       state, state_d;

  assign state = state_of(m_valid, s_valid);
  assign push  = In_Valid & in_ready_q;
  assign pop   = m_valid & Out_Ready;

  always_comb begin
    m_load   = 1'b0;
    m_clr    = 1'b0;
    m_from_s = 1'b0;
    s_load   = 1'b0;
    s_clr    = 1'b0;
    state_d  = state;
    if (Flush) begin
      m_clr   = 1'b1;
      s_clr   = 1'b1;
      state_d = ST_EMPTY;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (push) begin
            m_load  = 1'b1;
            state_d = ST_HALF;
          end
        end
        ST_HALF: begin
          if (push && pop) begin
            m_load = 1'b1;
          end else if (push) begin
            s_load  = 1'b1;
            state_d = ST_FULL;
          end else if (pop) begin
            m_clr   = 1'b1;
            state_d = ST_EMPTY;
          end
        end
        ST_FULL: begin
          // In_Ready is low here, so the only event is draining S into M
          if (pop) begin
            m_load   = 1'b1;
            m_from_s = 1'b1;
            s_clr    = 1'b1;
            state_d  = ST_HALF;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  assign m_ctrl_in  = m_from_s ? s_ctrl : In_Ctrl;
  assign m_data_in  = m_from_s ? s_data : In_Data;
  assign in_ready_d = (state_d != ST_FULL);

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) in_ready_q <= 1'b1;
    else          in_ready_q <= in_ready_d;
  end

  pipe_skid_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_main (
    .clk    (Clock),
    .rst_n  (Reset_n),
    .clr    (m_clr),
    .load   (m_load),
    .in_ctrl(m_ctrl_in),
    .in_data(m_data_in),
    .valid  (m_valid),
    .ctrl   (m_ctrl),
    .data   (m_data)
  );

  pipe_skid_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_skid (
    .clk    (Clock),
    .rst_n  (Reset_n),
    .clr    (s_clr),
    .load   (s_load),
    .in_ctrl(In_Ctrl),
    .in_data(In_Data),
    .valid  (s_valid),
    .ctrl   (s_ctrl),
    .data   (s_data)
  );

  assign In_Ready  = in_ready_q;
  assign Out_Valid = m_valid;
  assign Out_Ctrl  = m_valid ? m_ctrl : '0;
  assign Out_Data  = m_data;
  assign Occupancy = occ_of(state);

`ifdef PIPE_STAGE_PERF_EN
  logic [CNT_W-1:0] stall_cnt_d, stall_cnt_q;
  logic [CNT_W-1:0] bubble_cnt_d, bubble_cnt_q;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  always_comb begin
    stall_cnt_d  = stall_cnt_q;
    bubble_cnt_d = bubble_cnt_q;
    if (m_valid && !Out_Ready) stall_cnt_d = sat_inc(stall_cnt_q);
    if (!m_valid)              bubble_cnt_d = sat_inc(bubble_cnt_q);
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      stall_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      stall_cnt_q  <= stall_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign StallCount  = stall_cnt_q;
  assign BubbleCount = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed self-checking bench for pipe_stage_reg (default widths).
// Counter checks are included when PIPE_STAGE_PERF_EN is defined.
module tb_pipe_stage_reg;

  localparam int CTRL_W = 4;
  localparam int DATA_W = 128;
  localparam int CNT_W  = 32;

  logic              Clock = 1'b0;
  logic              Reset_n;
  logic              Flush;
  logic              In_Valid;
  logic              In_Ready;
  logic [CTRL_W-1:0] In_Ctrl;
  logic [DATA_W-1:0] In_Data;
  logic              Out_Valid;
  logic              Out_Ready;
  logic [CTRL_W-1:0] Out_Ctrl;
  logic [DATA_W-1:0] Out_Data;
  logic [1:0]        Occupancy;
`ifdef PIPE_STAGE_PERF_EN
  logic [CNT_W-1:0]  StallCount;
  logic [CNT_W-1:0]  BubbleCount;
`endif

  int checks = 0;
  int errors = 0;

  pipe_stage_reg #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .Clock      (Clock),
    .Reset_n    (Reset_n),
    .Flush      (Flush),
    .In_Valid   (In_Valid),
    .In_Ready   (In_Ready),
    .In_Ctrl    (In_Ctrl),
    .In_Data    (In_Data),
    .Out_Valid  (Out_Valid),
    .Out_Ready  (Out_Ready),
    .Out_Ctrl   (Out_Ctrl),
    .Out_Data   (Out_Data),
    .Occupancy  (Occupancy)
`ifdef PIPE_STAGE_PERF_EN
    ,
    .StallCount (StallCount),
    .BubbleCount(BubbleCount)
`endif
  );

  always #5 Clock = ~Clock;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle 1 time unit past it
  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    Reset_n   = 1'b0;
    Flush     = 1'b0;
    In_Valid  = 1'b0;
    In_Ctrl   = '0;
    In_Data   = '0;
    Out_Ready = 1'b0;
    step();
    step();
    chk("rst_in_ready",  128'(In_Ready),  128'd1);
    chk("rst_out_valid", 128'(Out_Valid), 128'd0);
    chk("rst_out_ctrl",  128'(Out_Ctrl),  128'd0);
    chk("rst_out_data",  Out_Data,        128'd0);
    chk("rst_occ",       128'(Occupancy), 128'd0);
`ifdef PIPE_STAGE_PERF_EN
    chk("rst_stall",  128'(StallCount),  128'd0);
    chk("rst_bubble", 128'(BubbleCount), 128'd0);
`endif
    Reset_n = 1'b1;

    // streaming 1..8
    In_Valid  = 1'b1;
    Out_Ready = 1'b1;
    In_Ctrl   = 4'h1;
    for (int i = 1; i <= 8; i++) begin
      In_Data = 128'(i);
      step();
      chk("stream_data",  Out_Data,        128'(i));
      chk("stream_valid", 128'(Out_Valid), 128'd1);
      chk("stream_occ",   128'(Occupancy), 128'd1);
      chk("stream_ready", 128'(In_Ready),  128'd1);
    end
    In_Valid = 1'b0;
    step();
    chk("drain_valid", 128'(Out_Valid), 128'd0);
    chk("drain_ctrl",  128'(Out_Ctrl),  128'd0);
    chk("drain_hold",  Out_Data,        128'd8);
    chk("drain_occ",   128'(Occupancy), 128'd0);

    // back-pressure A, B, then C held off
    Out_Ready = 1'b0;
    In_Valid  = 1'b1;
    In_Ctrl   = 4'h2;
    In_Data   = 128'hA;
    step();
    chk("bp_occ1", 128'(Occupancy), 128'd1);
    chk("bp_rdy1", 128'(In_Ready),  128'd1);
    In_Ctrl = 4'h3;
    In_Data = 128'hB;
    step();
    chk("bp_occ2", 128'(Occupancy), 128'd2);
    chk("bp_rdy2", 128'(In_Ready),  128'd0);
    chk("bp_outA", Out_Data,        128'hA);
    chk("bp_ctlA", 128'(Out_Ctrl),  128'h2);
    In_Ctrl = 4'h4;
    In_Data = 128'hC;
    step();
    chk("bp_hold_occ", 128'(Occupancy), 128'd2);
    chk("bp_hold_out", Out_Data,        128'hA);
    Out_Ready = 1'b1;
    step();
    chk("bp_outB",  Out_Data,        128'hB);
    chk("bp_ctlB",  128'(Out_Ctrl),  128'h3);
    chk("bp_occB",  128'(Occupancy), 128'd1);
    chk("bp_rdyB",  128'(In_Ready),  128'd1);
    step();
    chk("bp_outC",  Out_Data,        128'hC);
    chk("bp_ctlC",  128'(Out_Ctrl),  128'h4);
    In_Valid = 1'b0;
    step();
    chk("bp_empty", 128'(Out_Valid), 128'd0);

    // flush while FULL with 0xD offered
    Out_Ready = 1'b0;
    In_Valid  = 1'b1;
    In_Ctrl   = 4'h6;
    In_Data   = 128'h11;
    step();
    In_Data = 128'h12;
    step();
    chk("fl_full", 128'(Occupancy), 128'd2);
    In_Ctrl = 4'h7;
    In_Data = 128'hD;
    Flush   = 1'b1;
    step();
    Flush    = 1'b0;
    In_Valid = 1'b0;
    chk("fl_occ",   128'(Occupancy), 128'd0);
    chk("fl_valid", 128'(Out_Valid), 128'd0);
    chk("fl_ctrl",  128'(Out_Ctrl),  128'd0);
    chk("fl_ready", 128'(In_Ready),  128'd1);
    Out_Ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("fl_no_d_valid", 128'(Out_Valid), 128'd0);
      chk("fl_no_d_data",  Out_Data,        128'h11);
    end

    // bubble control: ctrl F for exactly one cycle
    In_Valid = 1'b1;
    In_Ctrl  = 4'hF;
    In_Data  = 128'h55;
    step();
    In_Valid = 1'b0;
    In_Ctrl  = 4'h0;
    chk("bub_ctrl_on", 128'(Out_Ctrl),  128'hF);
    chk("bub_valid",   128'(Out_Valid), 128'd1);
    step();
    chk("bub_ctrl_off1", 128'(Out_Ctrl), 128'h0);
    chk("bub_hold1",     Out_Data,       128'h55);
    step();
    chk("bub_ctrl_off2", 128'(Out_Ctrl), 128'h0);
    chk("bub_hold2",     Out_Data,       128'h55);

    // async reset mid-cycle while FULL
    Out_Ready = 1'b0;
    In_Valid  = 1'b1;
    In_Ctrl   = 4'h5;
    In_Data   = 128'h21;
    step();
    In_Data = 128'h22;
    step();
    In_Valid = 1'b0;
    chk("ar_full", 128'(Occupancy), 128'd2);
    #2;
    Reset_n = 1'b0;
    #1;
    chk("ar_valid", 128'(Out_Valid), 128'd0);
    chk("ar_ctrl",  128'(Out_Ctrl),  128'd0);
    chk("ar_data",  Out_Data,        128'd0);
    chk("ar_occ",   128'(Occupancy), 128'd0);
    chk("ar_ready", 128'(In_Ready),  128'd1);
`ifdef PIPE_STAGE_PERF_EN
    chk("ar_stall",  128'(StallCount),  128'd0);
    chk("ar_bubble", 128'(BubbleCount), 128'd0);
`endif
    #1;
    Reset_n = 1'b1;

`ifdef PIPE_STAGE_PERF_EN
    // 2 idle edges + 1 push edge (still empty) are bubbles, then 5 stalls, 1 pop, 3 idle
    step();
    step();
    In_Valid = 1'b1;
    In_Data  = 128'h77;
    step();
    In_Valid = 1'b0;
    for (int i = 0; i < 5; i++) step();
    chk("perf_stall_mid",  128'(StallCount),  128'd5);
    chk("perf_bubble_mid", 128'(BubbleCount), 128'd3);
    Out_Ready = 1'b1;
    step();
    for (int i = 0; i < 3; i++) step();
    chk("perf_stall",  128'(StallCount),  128'd5);
    chk("perf_bubble", 128'(BubbleCount), 128'd6);
`else
    step();
    chk("post_rst_ready", 128'(In_Ready),  128'd1);
    chk("post_rst_valid", 128'(Out_Valid), 128'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
